// File: rtl/joystick_beep_if.sv
// Joystick conditioner signal bundle: raw direction lines in, conditioned
// levels, press events and the buzzer enable out.
interface joystick_beep_if;
    logic [3:0] joy_raw;
    logic [3:0] joy_stable;
    logic       dir_pulse;
    logic [1:0] dir_code;
    logic       beep_en;
    logic [7:0] press_count;

    modport master (
        output joy_raw,
        input  joy_stable,
        input  dir_pulse,
        input  dir_code,
        input  beep_en,
        input  press_count
    );

    modport slave (
        input  joy_raw,
        output joy_stable,
        output dir_pulse,
        output dir_code,
        output beep_en,
        output press_count
    );
endinterface

// File: rtl/joystick_beep_ctrl.sv
// Joystick input conditioner: synchronise, debounce and edge-detect four
// direction lines, priority-encode presses and sequence a timed beep window.
module joystick_beep_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BEEP_CYCLES     = 5_000_000,
    parameter int GAP_CYCLES      = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    joystick_beep_if.slave joy_if
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (BW > GW) ? BW : GW;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] BEEP_LOAD = TW'(BEEP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEEP = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    logic [3:0]          sync1_q;
    logic [3:0]          sync2_q;
    logic [3:0]          joy_stable_q;
    logic [3:0]          joy_stable_d;
    logic [3:0]          joy_prev_q;
    logic [3:0]          rise_s;
    logic [3:0][DW-1:0]  deb_cnt_q;
    logic [3:0][DW-1:0]  deb_cnt_d;
    logic                ev_valid_q;
    logic                ev_valid_d;
    logic [1:0]          ev_code_q;
    logic [1:0]          ev_code_d;
    logic                dir_pulse_q;
    logic [1:0]          dir_code_q;
    logic [7:0]          press_count_q;
    state_e              state_q;
    logic [TW-1:0]       timer_q;
    logic                pending_q;
    logic                beep_en_q;

    // Highest set bit wins: up > down > left > right.
    function automatic logic [1:0] prio_code(input logic [3:0] r);
        logic [1:0] code;
        if (r[3]) begin
            code = 2'd3;
        end else if (r[2]) begin
            code = 2'd2;
        end else if (r[1]) begin
            code = 2'd1;
        end else begin
            code = 2'd0;
        end
        return code;
    endfunction

    // Two-flop synchroniser per raw line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= joy_if.joy_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-line debounce: count consecutive mismatches, flip once the run is long enough.
    always_comb begin
        deb_cnt_d    = deb_cnt_q;
        joy_stable_d = joy_stable_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == joy_stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_cnt_d[i]    = '0;
                joy_stable_d[i] = ~joy_stable_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    assign rise_s = joy_stable_q & ~joy_prev_q;

    // Rising edges only; lower-priority simultaneous presses are dropped.
    always_comb begin
        ev_valid_d = |rise_s;
        ev_code_d  = prio_code(rise_s);
    end

    // Debounce state, edge-detect copy and registered event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q    <= '0;
            joy_stable_q <= 4'b0000;
            joy_prev_q   <= 4'b0000;
            ev_valid_q   <= 1'b0;
            ev_code_q    <= 2'd0;
        end else begin
            deb_cnt_q    <= deb_cnt_d;
            joy_stable_q <= joy_stable_d;
            joy_prev_q   <= joy_stable_q;
            ev_valid_q   <= ev_valid_d;
            ev_code_q    <= ev_code_d;
        end
    end

    // Event outputs update on every press, independent of the beep sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_pulse_q   <= 1'b0;
            dir_code_q    <= 2'd0;
            press_count_q <= 8'd0;
        end else begin
            dir_pulse_q <= ev_valid_q;
            if (ev_valid_q) begin
                dir_code_q    <= ev_code_q;
                press_count_q <= press_count_q + 8'd1;
            end else begin
                dir_code_q    <= dir_code_q;
                press_count_q <= press_count_q;
            end
        end
    end

    // Beep sequencer; beep_en is registered alongside the state so it tracks BEEP exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
            beep_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pending_q <= 1'b0;
                    if (ev_valid_q) begin
                        state_q   <= ST_BEEP;
                        timer_q   <= BEEP_LOAD;
                        beep_en_q <= 1'b1;
                    end else begin
                        beep_en_q <= 1'b0;
                    end
                end
                ST_BEEP: begin
                    if (ev_valid_q) begin
                        timer_q   <= BEEP_LOAD;
                        beep_en_q <= 1'b1;
                    end else if (timer_q == '0) begin
                        state_q   <= ST_GAP;
                        timer_q   <= GAP_LOAD;
                        beep_en_q <= 1'b0;
                    end else begin
                        timer_q   <= timer_q - TW'(1);
                        beep_en_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    // A press on the final gap cycle still counts as pending.
                    if (timer_q == '0) begin
                        pending_q <= 1'b0;
                        if (pending_q || ev_valid_q) begin
                            state_q   <= ST_BEEP;
                            timer_q   <= BEEP_LOAD;
                            beep_en_q <= 1'b1;
                        end else begin
                            state_q   <= ST_IDLE;
                            beep_en_q <= 1'b0;
                        end
                    end else begin
                        timer_q   <= timer_q - TW'(1);
                        beep_en_q <= 1'b0;
                        pending_q <= pending_q | ev_valid_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    timer_q   <= '0;
                    pending_q <= 1'b0;
                    beep_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign joy_if.joy_stable  = joy_stable_q;
    assign joy_if.dir_pulse   = dir_pulse_q;
    assign joy_if.dir_code    = dir_code_q;
    assign joy_if.beep_en     = beep_en_q;
    assign joy_if.press_count = press_count_q;

endmodule

// File: tb/tb_joystick_beep_ctrl.sv
// Directed self-checking bench for joystick_beep_ctrl with short timing parameters.
module tb_joystick_beep_ctrl;

    localparam int D = 4;
    localparam int B = 10;
    localparam int G = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_count = 8'd0;
    logic beep_h [64];
    logic pulse_h [64];

    joystick_beep_if bus();

    joystick_beep_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .BEEP_CYCLES(B),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .joy_if(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 64; i++) begin
            beep_h[i]  = 1'b0;
            pulse_h[i] = 1'b0;
        end
    endtask

    // Ticks until dir_pulse is seen; n = ticks taken, or -1 if the limit expires.
    task automatic wait_pulse(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit && n < 0; i++) begin
            tick();
            if (bus.dir_pulse === 1'b1) n = i;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.joy_raw = 4'b0000;
        repeat (3) tick();
        checks++; if (bus.joy_stable !== 4'b0000) begin errors++; $display("FAIL reset_stable: got %b want 0000", bus.joy_stable); end
        checks++; if (bus.dir_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", bus.dir_pulse); end
        checks++; if (bus.dir_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", bus.dir_code); end
        checks++; if (bus.beep_en !== 1'b0) begin errors++; $display("FAIL reset_beep: got %b want 0", bus.beep_en); end
        checks++; if (bus.press_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.press_count); end
        rst_n = 1'b1;
        exp_count = 8'd0;
        repeat (2) tick();
    endtask

    task automatic test_clean_press();
        int pulses = 0, first_p = -1, highs = 0, first_b = -1, last_b = -1;
        bus.joy_raw = 4'b1000;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (bus.dir_pulse === 1'b1) begin pulses++; if (first_p < 0) first_p = t; end
            if (bus.beep_en === 1'b1) begin highs++; if (first_b < 0) first_b = t; last_b = t; end
        end
        exp_count = exp_count + 8'd1;
        checks++; if (first_p != 8) begin errors++; $display("FAIL clean_latency: got %0d want 8", first_p); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL clean_pulses: got %0d want 1", pulses); end
        checks++; if (bus.dir_code !== 2'd3) begin errors++; $display("FAIL clean_code: got %0d want 3", bus.dir_code); end
        checks++; if (bus.press_count !== exp_count) begin errors++; $display("FAIL clean_count: got %0d want %0d", bus.press_count, exp_count); end
        checks++; if (highs != 10) begin errors++; $display("FAIL clean_beep_len: got %0d want 10", highs); end
        checks++; if (first_b != 8 || last_b != 17) begin errors++; $display("FAIL clean_beep_span: got %0d..%0d want 8..17", first_b, last_b); end
        bus.joy_raw = 4'b0000;
        pulses = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus.dir_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL release_no_event: got %0d pulses want 0", pulses); end
        checks++; if (bus.joy_stable !== 4'b0000) begin errors++; $display("FAIL release_stable: got %b want 0000", bus.joy_stable); end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        logic seen = 1'b0;
        bus.joy_raw = 4'b0001;
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (t == 3) bus.joy_raw = 4'b0000;
            if (bus.joy_stable !== 4'b0000) seen = 1'b1;
            if (bus.dir_pulse === 1'b1) pulses++;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_stable: got %b want 0", seen); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulse: got %0d want 0", pulses); end
        checks++; if (bus.press_count !== exp_count) begin errors++; $display("FAIL glitch_count: got %0d want %0d", bus.press_count, exp_count); end
    endtask

    task automatic test_simultaneous();
        int n;
        int extra = 0;
        bus.joy_raw = 4'b0101;
        wait_pulse(20, n);
        exp_count = exp_count + 8'd1;
        checks++; if (n != 8) begin errors++; $display("FAIL simul_latency: got %0d want 8", n); end
        checks++; if (bus.dir_code !== 2'd2) begin errors++; $display("FAIL simul_code: got %0d want 2", bus.dir_code); end
        checks++; if (bus.press_count !== exp_count) begin errors++; $display("FAIL simul_count: got %0d want %0d", bus.press_count, exp_count); end
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (bus.dir_pulse === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL simul_not_queued: got %0d pulses want 0", extra); end
        bus.joy_raw = 4'b0100;
        repeat (12) tick();
        bus.joy_raw = 4'b0101;
        wait_pulse(20, n);
        exp_count = exp_count + 8'd1;
        checks++; if (n != 8) begin errors++; $display("FAIL repress_latency: got %0d want 8", n); end
        checks++; if (bus.dir_code !== 2'd0) begin errors++; $display("FAIL repress_code: got %0d want 0", bus.dir_code); end
        checks++; if (bus.press_count !== exp_count) begin errors++; $display("FAIL repress_count: got %0d want %0d", bus.press_count, exp_count); end
        bus.joy_raw = 4'b0000;
        repeat (40) tick();
    endtask

    task automatic test_retrigger();
        int pulses = 0, highs = 0, first_b = -1, last_b = -1;
        clear_hist();
        bus.joy_raw = 4'b1000;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 5) bus.joy_raw = 4'b1010;
            beep_h[t]  = bus.beep_en;
            pulse_h[t] = bus.dir_pulse;
            if (bus.dir_pulse === 1'b1) pulses++;
            if (bus.beep_en === 1'b1) begin highs++; if (first_b < 0) first_b = t; last_b = t; end
        end
        exp_count = exp_count + 8'd2;
        checks++; if (pulses != 2 || pulse_h[8] !== 1'b1 || pulse_h[13] !== 1'b1) begin errors++; $display("FAIL retrig_pulses: got %0d (t8=%b t13=%b) want 2 at 8,13", pulses, pulse_h[8], pulse_h[13]); end
        checks++; if (highs != 15) begin errors++; $display("FAIL retrig_beep_len: got %0d want 15", highs); end
        checks++; if (first_b != 8 || last_b != 22) begin errors++; $display("FAIL retrig_beep_span: got %0d..%0d want 8..22", first_b, last_b); end
        checks++; if (bus.dir_code !== 2'd1) begin errors++; $display("FAIL retrig_code: got %0d want 1", bus.dir_code); end
        checks++; if (bus.press_count !== exp_count) begin errors++; $display("FAIL retrig_count: got %0d want %0d", bus.press_count, exp_count); end
        bus.joy_raw = 4'b0000;
        repeat (20) tick();
    endtask

    task automatic test_gap_pending();
        int pulses = 0, highs = 0, last_b = -1;
        clear_hist();
        bus.joy_raw = 4'b1000;
        for (int t = 1; t <= 45; t++) begin
            tick();
            if (t == 11) bus.joy_raw = 4'b1100;
            if (t == 12) bus.joy_raw = 4'b1110;
            beep_h[t]  = bus.beep_en;
            pulse_h[t] = bus.dir_pulse;
            if (bus.dir_pulse === 1'b1) pulses++;
            if (bus.beep_en === 1'b1) begin highs++; last_b = t; end
        end
        exp_count = exp_count + 8'd3;
        checks++; if (pulses != 3 || pulse_h[19] !== 1'b1 || pulse_h[20] !== 1'b1) begin errors++; $display("FAIL gap_pulses: got %0d (t19=%b t20=%b) want 3", pulses, pulse_h[19], pulse_h[20]); end
        checks++; if ({beep_h[18], beep_h[19], beep_h[20]} !== 3'b000) begin errors++; $display("FAIL gap_silent: got %b%b%b want 000", beep_h[18], beep_h[19], beep_h[20]); end
        checks++; if (beep_h[21] !== 1'b1) begin errors++; $display("FAIL gap_resume: got %b want 1", beep_h[21]); end
        checks++; if (highs != 20 || last_b != 30) begin errors++; $display("FAIL gap_beep_total: got %0d ending %0d want 20 ending 30", highs, last_b); end
        checks++; if (bus.press_count !== exp_count) begin errors++; $display("FAIL gap_count: got %0d want %0d", bus.press_count, exp_count); end
        bus.joy_raw = 4'b0000;
        repeat (20) tick();
    endtask

    task automatic test_wrap();
        int n;
        int bad = 0;
        logic [7:0] start = exp_count;
        for (int p = 0; p < 256; p++) begin
            bus.joy_raw = 4'b0001;
            wait_pulse(12, n);
            if (n != 8) bad++;
            exp_count = exp_count + 8'd1;
            if (exp_count == 8'd0) begin
                checks++; if (bus.press_count !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", bus.press_count); end
            end
            bus.joy_raw = 4'b0000;
            repeat (9) tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_latency: got %0d late presses want 0", bad); end
        checks++; if (bus.press_count !== start) begin errors++; $display("FAIL wrap_full: got %0d want %0d", bus.press_count, start); end
    endtask

    task automatic test_reset_mid_beep();
        int n;
        int highs = 0;
        bus.joy_raw = 4'b1000;
        wait_pulse(12, n);
        repeat (3) tick();
        checks++; if (bus.beep_en !== 1'b1) begin errors++; $display("FAIL midbeep_active: got %b want 1", bus.beep_en); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.beep_en !== 1'b0) begin errors++; $display("FAIL async_beep: got %b want 0", bus.beep_en); end
        checks++; if (bus.press_count !== 8'd0 || bus.dir_pulse !== 1'b0) begin errors++; $display("FAIL async_count_pulse: got %0d/%b want 0/0", bus.press_count, bus.dir_pulse); end
        checks++; if (bus.joy_stable !== 4'b0000) begin errors++; $display("FAIL async_stable: got %b want 0000", bus.joy_stable); end
        bus.joy_raw = 4'b0000;
        repeat (3) tick();
        rst_n = 1'b1;
        exp_count = 8'd0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (bus.beep_en === 1'b1) highs++;
        end
        checks++; if (highs != 0) begin errors++; $display("FAIL post_reset_idle: got %0d beep cycles want 0", highs); end
        bus.joy_raw = 4'b0001;
        wait_pulse(12, n);
        exp_count = exp_count + 8'd1;
        checks++; if (n != 8 || bus.beep_en !== 1'b1) begin errors++; $display("FAIL post_reset_press: got lat %0d beep %b want 8/1", n, bus.beep_en); end
        checks++; if (bus.press_count !== exp_count || bus.dir_code !== 2'd0) begin errors++; $display("FAIL post_reset_count: got %0d code %0d want %0d code 0", bus.press_count, bus.dir_code, exp_count); end
    endtask

    initial begin
        bus.joy_raw = 4'b0000;
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_retrigger();
        test_gap_pending();
        test_wrap();
        test_reset_mid_beep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
